// File: rtl/ram64_pkg.sv
// Shared sizing constants and address-field helpers for the RAM hierarchy
// (ram8 today, ram512/ram4k stages later).
package ram64_pkg;

    // Default data word width in bits.
    localparam int WIDTH_DEFAULT = 16;

    // Address split: upper field picks the bank, lower field picks the word.
    localparam int BANK_BITS = 3;
    localparam int WORD_BITS = 3;
    localparam int ADDR_BITS = BANK_BITS + WORD_BITS;

    localparam int BANKS = 1 << BANK_BITS;
    localparam int WORDS = 1 << WORD_BITS;

    // Bank index carried in the upper address bits.
    function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_BITS-1:0] a);
        return a[ADDR_BITS-1:WORD_BITS];
    endfunction

    // Word index within a bank, carried in the lower address bits.
    function automatic logic [WORD_BITS-1:0] word_of(input logic [ADDR_BITS-1:0] a);
        return a[WORD_BITS-1:0];
    endfunction

endpackage

// File: rtl/dmux8.sv
// 1-to-8 demultiplexer: routes d to the output selected by addr, all other
// outputs are 0. Result is one-hot when d=1 and all-zero when d=0.
module dmux8 (
    input  logic       d,
    input  logic [2:0] addr,
    output logic [7:0] out
);

    // Default every output low, then steer d onto the selected line.
    always_comb begin
        out       = '0;
        out[addr] = d;
    end

endmodule

// File: rtl/ram8.sv
// Eight-word register bank with asynchronous active-low clear and a
// combinational read port. The write enable is decoded per word by dmux8.
module ram8
    import ram64_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic                 load,
    input  logic [WORD_BITS-1:0] addr,
    output logic [WIDTH-1:0]     out
);

    logic [WORDS-1:0] word_load;
    logic [WIDTH-1:0] regs [WORDS];

    dmux8 u_word_dmux (
        .d    (load),
        .addr (addr),
        .out  (word_load)
    );

    // Word storage: async clear to zero, otherwise only the decoded word loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (word_load[i]) begin
                    regs[i] <= in;
                end
            end
        end
    end

    // Read is purely combinational, so the pre-edge value shows during a write.
    assign out = regs[addr];

endmodule

// File: rtl/ram64.sv
// 64-word RAM built from eight ram8 banks. addr[5:3] selects the bank for
// both the write-enable decode and the read mux; addr[2:0] goes to every bank.
module ram64
    import ram64_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [WIDTH-1:0]     out
);

    logic [BANK_BITS-1:0] bank_sel;
    logic [WORD_BITS-1:0] word_sel;
    logic [BANKS-1:0]     bank_load;
    logic [WIDTH-1:0]     bank_out [BANKS];

    assign bank_sel = bank_of(addr);
    assign word_sel = word_of(addr);

    dmux8 u_bank_dmux (
        .d    (load),
        .addr (bank_sel),
        .out  (bank_load)
    );

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ram8 #(
            .WIDTH (WIDTH)
        ) u_ram8 (
            .clk   (clk),
            .rst_n (rst_n),
            .in    (in),
            .load  (bank_load[b]),
            .addr  (word_sel),
            .out   (bank_out[b])
        );
    end

    // 8-way output mux on the bank field; no register on the read path.
    always_comb begin
        out = bank_out[bank_sel];
    end

endmodule

// File: tb/tb_ram64.sv
// Self-checking bench for ram64: directed scenarios plus randomized traffic,
// compared against a plain 64-entry array model.
module tb_ram64;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in;
    logic         load;
    logic [5:0]   addr;
    logic [W-1:0] out;

    logic [W-1:0] model [64];
    logic [W-1:0] snap  [64];

    int checks;
    int errors;

    ram64 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .load  (load),
        .addr  (addr),
        .out   (out)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = '0;
    endtask

    // Single write: drive on the falling edge, commit at the rising edge.
    task automatic write_word(input logic [5:0] a, input logic [W-1:0] d);
        @(negedge clk);
        addr = a;
        in   = d;
        load = 1'b1;
        @(posedge clk);
        #1;
        model[a] = d;
        load = 1'b0;
    endtask

    // Combinational read checked against the model without any clock edge.
    task automatic read_check(input string tag, input logic [5:0] a);
        addr = a;
        #1;
        check(tag, out, model[a]);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 64; i++) read_check(tag, 6'(i));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        in     = '0;
        load   = 1'b0;
        addr   = '0;
        rst_n  = 1'b0;
        model_clear();

        // Reset state.
        #2;
        read_check("reset_a0", 6'd0);
        read_check("reset_a63", 6'd63);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with FFFF, then async reset between edges clears everything.
        for (int i = 0; i < 64; i++) write_word(6'(i), 16'hFFFF);
        read_check("fill_ffff", 6'd37);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        addr = 6'd12;
        #0.5;
        check("reset_immediate", out, 16'h0000);
        read_all("reset_clear");
        @(negedge clk);
        rst_n = 1'b1;

        // Single write isolation.
        write_word(6'd9, 16'h1234);
        read_check("iso_a9", 6'd9);
        read_check("iso_a1", 6'd1);
        read_check("iso_a8", 6'd8);
        read_check("iso_a10", 6'd10);
        read_check("iso_a17", 6'd17);
        read_check("iso_a41", 6'd41);

        // Bank boundary sweep: each address holds its own index.
        for (int i = 0; i < 64; i++) write_word(6'(i), W'(i));
        addr = 6'd7; #1; check("sweep_a7", out, 16'd7);
        addr = 6'd8; #1; check("sweep_a8", out, 16'd8);
        read_all("sweep");

        // Read-during-write on word 63: old value before the edge, new after.
        write_word(6'd63, 16'hAAAA);
        @(negedge clk);
        addr = 6'd63;
        in   = 16'h5555;
        load = 1'b1;
        #1;
        check("rdw_before", out, 16'hAAAA);
        @(posedge clk);
        #1;
        load = 1'b0;
        model[63] = 16'h5555;
        check("rdw_after", out, 16'h5555);

        // load=0 for 64 cycles must change nothing.
        for (int i = 0; i < 64; i++) snap[i] = model[i];
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            addr = 6'(i);
            in   = 16'hBEEF;
            load = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i);
            #1;
            check("hold", out, snap[i]);
        end

        // Reset overrides a coincident write.
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b1;
        in    = 16'h7777;
        addr  = 6'd5;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        read_check("rst_vs_load_a5", 6'd5);

        // First edge after release accepts a write.
        write_word(6'd5, 16'h0F0F);
        read_check("first_write_after_rst", 6'd5);

        // Back-to-back writes, same address then neighbouring addresses.
        write_word(6'd20, 16'h1111);
        write_word(6'd20, 16'h2222);
        write_word(6'd21, 16'h3333);
        write_word(6'd28, 16'h4444);
        read_check("b2b_a20", 6'd20);
        read_check("b2b_a21", 6'd21);
        read_check("b2b_a28", 6'd28);

        // Randomized traffic: every cycle check the pre-edge read, then commit.
        for (int n = 0; n < 400; n++) begin
            logic [5:0]   ra;
            logic [W-1:0] rd;
            logic         rl;
            ra = 6'($urandom_range(0, 63));
            rd = W'($urandom);
            rl = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            addr = ra;
            in   = rd;
            load = rl;
            #1;
            check("rand_pre_edge", out, model[ra]);
            @(posedge clk);
            #1;
            if (rl) model[ra] = rd;
            check("rand_post_edge", out, model[ra]);
            if ($urandom_range(0, 7) == 0) begin
                load = 1'b0;
                read_check("rand_peek", 6'($urandom_range(0, 63)));
            end
        end
        load = 1'b0;
        @(negedge clk);
        read_all("rand_final");

        // Mid-sequence reset clears previously written words.
        #1;
        rst_n = 1'b0;
        model_clear();
        read_all("midseq_reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram64.md
RAM64 -- requirements
Module: ram64

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 clk  input  1  clock; all storage updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in  input  WIDTH  write data.
REQ-005 load  input  1  write enable; sampled at the rising clk edge.
REQ-006 addr  input  6  word address; addr[5:3] selects the bank and addr[2:0] selects the word within the bank.
REQ-007 out  output  WIDTH  read data for the word at addr.

Function
REQ-008 The block SHALL hold 64 words of WIDTH bits, organised as 8 banks of 8 words.
REQ-009 A write SHALL occur on a rising clk edge when load=1 and rst_n=1: word[addr] <= in.
REQ-010 When load=0, no word SHALL change.
REQ-011 A write SHALL modify exactly one word; the other 63 words SHALL hold their values.
REQ-012 Bank load enables SHALL be one-hot-or-zero:
- bank_load[addr[5:3]] = load
- all other bank_load bits = 0
- produced by 1-to-8 demux semantics, identical to dmux8 with d=load and addr=addr[5:3].
REQ-013 Within the selected bank, the same demux rule SHALL apply on addr[2:0].
REQ-014 Read SHALL be combinational: out = word[addr] with zero-cycle latency.
- When addr changes, out SHALL follow in the same cycle with no clock required.
REQ-015 Read-during-write: in the cycle where load=1, out SHALL show the old contents of word[addr].
- After the rising edge, out SHALL show the newly written value.
- No write-through bypass.
REQ-016 addr and in SHALL be sampled only at the rising clk edge for writes.
- Glitches between edges SHALL NOT corrupt storage.
REQ-017 All 64 addresses SHALL be valid; there is no out-of-range condition and no wrap behaviour beyond the 6-bit field.
REQ-018 Back-to-back writes to the same or different addresses on consecutive cycles SHALL each take effect at their own edge.

Reset
REQ-019 While rst_n=0, all 64 words SHALL be forced to 0 immediately, independent of clk.
- out SHALL read 0 for every addr.
REQ-020 Reset SHALL override load: a write coinciding with an asserted rst_n SHALL be discarded.
REQ-021 Writes SHALL be accepted starting at the first rising clk edge after rst_n deasserts.
REQ-022 Reset asserted mid-sequence SHALL clear all words, including words written earlier.

Structure
REQ-023 A shared package SHALL hold the following, reused by ram8 and later ram512/ram4k stages:
- WIDTH default (16)
- BANK_BITS (3)
- WORD_BITS (3)
REQ-024 The block SHALL instantiate eight copies of sub-module ram8.
- ram8 ports: clk, rst_n, in[WIDTH], load, addr[3], out[WIDTH].
- Each ram8 contains 8 WIDTH-bit registers with async active-low clear.
REQ-025 Bank load decode SHALL use the existing dmux8.
REQ-026 Bank output selection SHALL use an 8-way WIDTH-bit mux on addr[5:3].
REQ-027 There SHALL be no additional pipeline registers on read or write paths.

Verification
REQ-028 Reset clear: write 16'hFFFF to all 64 addresses, pulse rst_n low between clock edges -> out = 16'h0000 immediately for every addr, before any clk edge.
REQ-029 Single write isolation: after reset, write in=16'h1234 at addr=6'd9 -> out=16'h1234 at addr 9; out=0 at addrs 1, 8, 10, 17, 41.
REQ-030 Bank boundary sweep: write value = {10'b0, addr} at every addr 0..63 -> each addr reads back its own index; addr 7 reads 7 and addr 8 reads 8.
REQ-031 Read-during-write: word 63 holds 16'hAAAA; drive load=1, in=16'h5555, addr=63 -> out=16'hAAAA before the edge and 16'h5555 after it.
REQ-032 load=0 hold: drive in=16'hBEEF on all addrs with load=0 for 64 cycles -> all prior contents unchanged.
REQ-033 Reset vs load collision: assert rst_n=0 with load=1, in=16'h7777, addr=5 across a clk edge -> word 5 reads 0 after reset releases.
